// File: rtl/eater_pkg.sv
// Shared types and constants for the eater serial output path.
// Holds the formatter/UART state encodings and the record character helper.
package eater_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    localparam int CHARS_PER_RECORD = 5;
    localparam int DIV_CYCLES       = 11;
    localparam int HUNDREDS_STEPS   = 2;

    typedef enum logic [2:0] {
        FMT_IDLE,
        FMT_POP,
        FMT_DIV,
        FMT_SEND,
        FMT_WAIT
    } fmt_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_phase_t;

    // Character idx of a record: three decimal digits, then CR LF.
    function automatic logic [7:0] record_char(
        input logic [2:0] idx,
        input logic [3:0] hundreds,
        input logic [3:0] tens,
        input logic [7:0] ones
    );
        logic [7:0] c;
        case (idx)
            3'd0:    c = ASCII_ZERO + {4'h0, hundreds};
            3'd1:    c = ASCII_ZERO + {4'h0, tens};
            3'd2:    c = ASCII_ZERO + ones;
            3'd3:    c = ASCII_CR;
            default: c = ASCII_LF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/eater_uart_out_uart_tx.sv
// 8N1 UART transmitter. A byte is accepted on tx_valid_i && tx_ready_o; ready is
// also raised in the last stop-bit cycle so consecutive characters have no gap.
module uart_tx
    import eater_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       tx_o,
    output logic       idle_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    tx_phase_t        r_phase;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;

    logic w_bit_end;
    logic w_ready;
    logic w_load;

    assign w_bit_end = (r_clk_cnt == LAST_CNT);
    assign w_ready   = (r_phase == TX_IDLE) || ((r_phase == TX_STOP) && w_bit_end);
    assign w_load    = tx_valid_i && w_ready;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_phase   <= TX_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else if (w_load) begin
            r_phase   <= TX_START;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= tx_data_i;
            r_tx      <= 1'b0;
        end else begin
            case (r_phase)
                TX_IDLE: begin
                    r_clk_cnt <= '0;
                    r_tx      <= 1'b1;
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_phase   <= TX_DATA;
                        r_clk_cnt <= '0;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_phase <= TX_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            // LSB first: the next bit out is shift[1] before the shift lands.
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (w_bit_end) begin
                        r_phase   <= TX_IDLE;
                        r_clk_cnt <= '0;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    r_phase <= TX_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_ready_o = w_ready;
    assign tx_o       = r_tx;
    assign idle_o     = (r_phase == TX_IDLE);

endmodule

// File: rtl/eater_uart_out.sv
// Eater CPU serial output: buffers OI bytes in a FIFO, formats each as three
// decimal ASCII digits plus CR LF, and sends the record over 8N1 UART.
module eater_uart_out
    import eater_pkg::*;
#(
    parameter int CLKS_PER_BIT    = 104,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       out_valid_i,
    input  logic [7:0] out_data_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       overflow_o
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);
    localparam logic [3:0] HUND_END  = 4'(HUNDREDS_STEPS);
    localparam logic [2:0] LAST_IDX  = 3'(CHARS_PER_RECORD - 1);

    logic [7:0]                 r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   r_count;
    logic                       r_overflow;

    fmt_state_t r_state;
    logic [7:0] r_value;
    logic [3:0] r_hundreds;
    logic [3:0] r_tens;
    logic [3:0] r_div_cnt;
    logic [2:0] r_idx;

    logic       w_fifo_empty;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic       w_tx_valid;
    logic       w_tx_ready;
    logic       w_tx_idle;
    logic [2:0] w_char_idx;
    logic [7:0] w_tx_data;

    assign w_fifo_empty = (r_count == '0);
    assign w_pop        = (r_state == FMT_IDLE) && !w_fifo_empty;
    assign w_push       = out_valid_i && ((r_count != DEPTH_CNT) || w_pop);
    assign w_drop       = out_valid_i && !w_push;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= out_data_i;
    end

    // Character 0 only needs the hundreds digit, which is final after the first
    // two DIV steps, so it is offered in the last DIV cycle. In WAIT the next
    // character is offered so it loads in the last stop-bit cycle of the current one.
    assign w_char_idx = (r_state == FMT_WAIT) ? (r_idx + 3'd1) : r_idx;
    assign w_tx_valid = (r_state == FMT_SEND)
                     || ((r_state == FMT_DIV) && (r_div_cnt == DIV_LAST))
                     || ((r_state == FMT_WAIT) && (r_idx != LAST_IDX));
    assign w_tx_data  = record_char(w_char_idx, r_hundreds, r_tens, r_value);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= FMT_IDLE;
            r_value    <= '0;
            r_hundreds <= '0;
            r_tens     <= '0;
            r_div_cnt  <= '0;
            r_idx      <= '0;
        end else begin
            case (r_state)
                FMT_IDLE: begin
                    if (w_pop) begin
                        r_value <= r_mem[r_rd_ptr];
                        r_state <= FMT_POP;
                    end
                end
                FMT_POP: begin
                    r_hundreds <= '0;
                    r_tens     <= '0;
                    r_div_cnt  <= '0;
                    r_idx      <= '0;
                    r_state    <= FMT_DIV;
                end
                FMT_DIV: begin
                    if (r_div_cnt < HUND_END) begin
                        if (r_value >= 8'd100) begin
                            r_value    <= r_value - 8'd100;
                            r_hundreds <= r_hundreds + 4'd1;
                        end
                    end else if (r_value >= 8'd10) begin
                        r_value <= r_value - 8'd10;
                        r_tens  <= r_tens + 4'd1;
                    end
                    if (r_div_cnt == DIV_LAST) begin
                        r_state <= w_tx_ready ? FMT_WAIT : FMT_SEND;
                    end else begin
                        r_div_cnt <= r_div_cnt + 4'd1;
                    end
                end
                FMT_SEND: begin
                    if (w_tx_ready) r_state <= FMT_WAIT;
                end
                FMT_WAIT: begin
                    if (w_tx_ready) begin
                        if (r_idx == LAST_IDX) r_state <= FMT_IDLE;
                        else                   r_idx   <= r_idx + 3'd1;
                    end
                end
                default: r_state <= FMT_IDLE;
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .tx_valid_i (w_tx_valid),
        .tx_data_i  (w_tx_data),
        .tx_ready_o (w_tx_ready),
        .tx_o       (tx_o),
        .idle_o     (w_tx_idle)
    );

    assign busy_o     = !w_fifo_empty || (r_state != FMT_IDLE) || !w_tx_idle;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_eater_uart_out.sv
// Bench for eater_uart_out: a timing-level model predicts tx_o, busy_o and
// overflow_o every cycle from the pushes, the record latency and UART framing.
module tb_eater_uart_out;

    localparam int CPB       = 4;
    localparam int CHAR_CYC  = 10 * CPB;
    localparam int REC_CYC   = 5 * CHAR_CYC;
    localparam int START_LAT = 13;  // pop cycle to first start-bit cycle
    localparam int DEPTH     = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       out_valid = 1'b0;
    logic [7:0] out_data = 8'h00;
    logic       tx;
    logic       busy;
    logic       overflow;

    eater_uart_out #(
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH_LOG2 (2)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .out_valid_i (out_valid),
        .out_data_i  (out_data),
        .tx_o        (tx),
        .busy_o      (busy),
        .overflow_o  (overflow)
    );

    // clock/reset block
    always #5 clk = ~clk;

    int cyc = 0;
    int last_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // scoreboard: bytes waiting in the FIFO, and the record currently on the line
    logic [7:0] exp_q[$];
    int         free_at = 0;
    int         rec_start = -1;
    logic [7:0] rec_chars[5];
    logic       exp_ovf = 1'b0;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, last_cyc, got, want);
        end
    endtask

    function automatic logic exp_tx();
        int off;
        int k;
        int b;
        logic [7:0] ch;
        if (rec_start < 0 || last_cyc < rec_start || last_cyc >= rec_start + REC_CYC) return 1'b1;
        off = last_cyc - rec_start;
        k   = off / CHAR_CYC;
        b   = (off % CHAR_CYC) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        ch = rec_chars[k];
        return ch[b-1];
    endfunction

    task automatic model_update(input logic rst, input logic v, input logic [7:0] d);
        int  pre;
        bit  pop;
        int  val;
        if (rst) begin
            exp_q.delete();
            free_at   = 0;
            rec_start = -1;
            exp_ovf   = 1'b0;
        end else begin
            pre = exp_q.size();
            pop = (pre > 0) && (last_cyc >= free_at);
            if (pop) begin
                val          = int'(exp_q.pop_front());
                rec_start    = last_cyc + START_LAT;
                free_at      = rec_start + REC_CYC;
                rec_chars[0] = 8'(48 + val / 100);
                rec_chars[1] = 8'(48 + (val / 10) % 10);
                rec_chars[2] = 8'(48 + val % 10);
                rec_chars[3] = 8'h0D;
                rec_chars[4] = 8'h0A;
            end
            if (v) begin
                if (pre < DEPTH || pop) exp_q.push_back(d);
                else                    exp_ovf = 1'b1;
            end
        end
    endtask

    // driver: one clock cycle; check outputs, then drive inputs for this cycle
    task automatic step(input logic rst, input logic v, input logic [7:0] d);
        @(negedge clk);
        last_cyc = cyc;
        check_val("tx", {7'h0, tx}, {7'h0, exp_tx()});
        check_val("busy", {7'h0, busy}, {7'h0, (exp_q.size() > 0) || (last_cyc < free_at)});
        check_val("ovf", {7'h0, overflow}, {7'h0, exp_ovf});
        reset     = rst;
        out_valid = v;
        out_data  = d;
        model_update(rst, v, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b0, 1'b1, d);
    endtask

    // idle until the next step lands on cycle t
    task automatic run_until(input int t);
        for (int i = 0; i < 100000 && last_cyc + 1 < t; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    int t;

    initial begin
        // 1: reset then quiet line
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
        idle(1000);
        check_val("t1_tx_idle", {7'h0, tx}, 8'h01);
        check_val("t1_busy_idle", {7'h0, busy}, 8'h00);

        // 2: 0xFF -> "255\r\n"
        push(8'hFF);
        idle(13);
        check_val("t2_pre_start", {7'h0, tx}, 8'h01);
        idle(1);
        check_val("t2_start_bit", {7'h0, tx}, 8'h00);
        idle(REC_CYC + 20);
        check_val("t2_busy_done", {7'h0, busy}, 8'h00);

        // 3: boundary values
        push(8'd0);   idle(999);
        push(8'd100); idle(999);
        push(8'd9);   idle(999);

        // 4: burst of six into depth four
        push(8'd10); push(8'd20); push(8'd30); push(8'd40); push(8'd50); push(8'd60);
        idle(1);
        check_val("t4_ovf_set", {7'h0, overflow}, 8'h01);
        idle(5 * (START_LAT + REC_CYC) + 50);
        check_val("t4_ovf_sticky", {7'h0, overflow}, 8'h01);
        step(1'b1, 1'b0, 8'h00);
        idle(1);
        check_val("t4_ovf_cleared", {7'h0, overflow}, 8'h00);

        // 5: reset during data bit 3 of the second character
        push(8'h2A);
        t = rec_start + CHAR_CYC + 4 * CPB + 1;
        run_until(t);
        step(1'b1, 1'b0, 8'h00);
        idle(1);
        check_val("t5_tx_after_rst", {7'h0, tx}, 8'h01);
        check_val("t5_busy_after_rst", {7'h0, busy}, 8'h00);
        idle(2000);

        // 6: FIFO full while the engine returns to idle, push on the pop cycle
        push(8'd201); push(8'd7); push(8'd77); push(8'd128); push(8'd255);
        check_val("t6_full", 8'(exp_q.size()), 8'd4);
        run_until(free_at);
        push(8'd42);
        idle(1);
        check_val("t6_no_ovf", {7'h0, overflow}, 8'h00);
        idle(6 * (START_LAT + REC_CYC) + 50);

        // random traffic
        for (int n = 0; n < 40; n++) begin
            idle($urandom_range(0, 150));
            for (int b = 0; b < int'($urandom_range(1, 3)); b++) push(8'($urandom_range(0, 255)));
        end
        idle(6 * (START_LAT + REC_CYC) + 50);
        check_val("end_busy", {7'h0, busy}, 8'h00);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
